// File: rtl/uart_rx_if.sv
// UART receiver bus: serial line and baud tick in, received word and status out.
interface uart_rx_if;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  // Line/tick driver side.
  modport master (
    output s_tick, rx,
    input  dout, rx_done_tick, frame_err, parity_err
  );

  // Receiver side.
  modport slave (
    input  s_tick, rx,
    output dout, rx_done_tick, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, optional parity and configurable stop length.
// The line is synchronized first; all decisions use the synchronized value.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PAR_EN  = 0,
  parameter int PAR_ODD = 0
) (
  input  logic      clk,
  input  logic      reset_n,
  uart_rx_if.slave  bus
);

  localparam int SW = (SB_TICK == 16) ? 4 : 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic [1:0]    r_sync;
  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_s, w_s_nxt;
  logic [2:0]    r_n, w_n_nxt;
  logic [7:0]    r_b, w_b_nxt;
  logic          r_p, w_p_nxt;
  logic          w_done;
  logic          w_rx_s;
  logic [7:0]    w_dout;
  logic          w_mismatch;

  logic [7:0]    r_dout;
  logic          r_done;
  logic          r_ferr;
  logic          r_perr;

  // Parity mismatch over the right-justified data word plus received parity bit.
  function automatic logic parity_mismatch(input logic [7:0] data, input logic p, input logic odd);
    parity_mismatch = (^data) ^ p ^ odd;
  endfunction

  assign w_rx_s     = r_sync[1];
  assign w_dout     = r_b >> (8 - DBIT);
  assign w_mismatch = parity_mismatch(w_dout, r_p, 1'(PAR_ODD));

  // Two-flop synchronizer for the asynchronous serial line, idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.rx};
    end
  end

  // FSM state, tick counter, bit counter, shift register and parity bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= 3'd0;
      r_b     <= 8'd0;
      r_p     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
      r_p     <= w_p_nxt;
    end
  end

  // Next-state logic; only IDLE->START may advance without an s_tick.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_p_nxt     = r_p;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_s_nxt     = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (r_s == SW'(7)) begin
            if (!w_rx_s) begin
              w_state_nxt = DATA;
              w_s_nxt     = '0;
              w_n_nxt     = 3'd0;
            end else begin
              w_state_nxt = IDLE;   // glitch: too short to be a start bit
            end
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end else begin
          w_s_nxt = r_s;
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (r_s == SW'(15)) begin
            w_s_nxt = '0;
            w_b_nxt = {w_rx_s, r_b[7:1]};
            if (r_n == 3'(DBIT - 1)) begin
              w_state_nxt = (PAR_EN != 0) ? PARITY : STOP;
            end else begin
              w_n_nxt = r_n + 3'd1;
            end
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end else begin
          w_s_nxt = r_s;
        end
      end
      PARITY: begin
        if (bus.s_tick) begin
          if (r_s == SW'(15)) begin
            w_p_nxt     = w_rx_s;
            w_s_nxt     = '0;
            w_state_nxt = STOP;
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end else begin
          w_s_nxt = r_s;
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (r_s == SW'(SB_TICK - 1)) begin
            w_state_nxt = IDLE;
            w_done      = 1'b1;
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end else begin
          w_s_nxt = r_s;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_s_nxt     = '0;
        w_n_nxt     = 3'd0;
      end
    endcase
  end

  // Registered frame results, updated together when a frame completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
      r_dout <= 8'd0;
      r_ferr <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_done <= w_done;
      if (w_done) begin
        r_dout <= w_dout;
        r_ferr <= ~w_rx_s;
        r_perr <= (PAR_EN != 0) & w_mismatch;
      end
    end
  end

  assign bus.dout         = r_dout;
  assign bus.rx_done_tick = r_done;
  assign bus.frame_err    = r_ferr;
  assign bus.parity_err   = r_perr;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8: data bits per frame; legal values 7 and 8.
REQ-002 Parameter SB_TICK, default 16: s_tick count for the stop bit; 16 gives 1 stop bit, 32 gives 2 stop bits.
REQ-003 Parameter PAR_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-004 Parameter PAR_ODD, default 0: with PAR_EN=1, 1 selects odd parity and 0 selects even parity.
REQ-005 Port clk, input, 1: single clock; all logic rising-edge.
REQ-006 Port reset_n, input, 1: asynchronous active-low reset.
REQ-007 Port s_tick, input, 1: one-clk enable pulse at 16x baud rate.
REQ-008 Port rx, input, 1: asynchronous serial line, idle high.
REQ-009 Port dout, output, 8: received data word, right-justified; for DBIT=7, dout[7]=0.
REQ-010 Port rx_done_tick, output, 1: one-clk pulse; a frame has completed.
REQ-011 Port frame_err, output, 1: the completed frame had a low stop-bit sample.
REQ-012 Port parity_err, output, 1: the completed frame had a parity mismatch; always 0 when PAR_EN=0.

Function
REQ-013 rx shall pass through a 2-flop synchronizer, reset value 1; all FSM sampling uses the synchronized value (rx_s).
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP; a tick counter s (4 bits when SB_TICK=16, otherwise 5 bits); a bit counter n (3 bits); a shift register b (8 bits).
REQ-015 IDLE: when rx_s==0, go to START and clear s; s_tick is not required for this transition.
REQ-016 START: on each s_tick increment s; at the s_tick where s==7 (mid start bit):
- rx_s==0: clear s and n, go to DATA.
- rx_s==1: treat as a glitch, return to IDLE with no rx_done_tick.
REQ-017 DATA: on each s_tick increment s; at s==15:
- clear s and shift b right, inserting rx_s at bit 7 (LSB first on the line).
- if n==DBIT-1, go to PARITY when PAR_EN=1, else to STOP; otherwise increment n.
REQ-018 PARITY: at the s_tick where s==15, capture rx_s as the parity bit p, clear s, go to STOP.
REQ-019 Parity check: mismatch = (XOR of the DBIT data bits) ^ p ^ PAR_ODD.
REQ-020 STOP: on each s_tick increment s; at s==SB_TICK-1, sample rx_s and go to IDLE; the s_tick cadence keeps this sample mid-bit.
REQ-021 One clk after the s_tick of REQ-020, registered outputs shall update together:
- rx_done_tick=1 for exactly one clk.
- dout = b >> (8-DBIT).
- frame_err = ~stop sample.
- parity_err = PAR_EN & mismatch.
REQ-022 dout, frame_err and parity_err shall hold their values until the next rx_done_tick; a frame with frame_err=1 still updates dout.
REQ-023 Returning to IDLE after STOP: if rx_s is already low (back-to-back frame), enter START on the next clk with no lost frame.
REQ-024 Clks without s_tick shall not change s, n, b or the state, except for the IDLE->START transition.
REQ-025 Line held low (break condition): produces a frame with dout=0x00 and frame_err=1, then an immediate START.

Reset
REQ-026 While reset_n is low:
- state=IDLE; s, n and b = 0.
- synchronizer flops = 1.
- dout=0x00; rx_done_tick, frame_err and parity_err = 0.
REQ-027 Reset asserted mid-frame shall abort the frame with no rx_done_tick; after release, reception resumes at the next falling edge of rx_s.

Verification
REQ-028 Default parameters, s_tick every clk, frame 0x55 with stop=1 -> one rx_done_tick; dout=0x55; frame_err=0; parity_err=0.
REQ-029 rx low for 4 s_ticks then high -> no rx_done_tick; FSM back in IDLE; dout unchanged.
REQ-030 Frame 0xA3 with stop bit driven 0 -> dout=0xA3, frame_err=1; a following good frame 0x0F -> dout=0x0F, frame_err=0.
REQ-031 PAR_EN=1, PAR_ODD=0, data 0x07 with parity 1 -> parity_err=0; same data with parity 0 -> parity_err=1.
REQ-032 Two back-to-back frames 0x12 and 0x34 with no idle gap, s_tick every 4 clks -> two rx_done_tick pulses with dout 0x12 then 0x34.
REQ-033 reset_n pulsed low during DATA bit 3 -> all outputs at reset values, no rx_done_tick; the next full frame 0xC6 is received correctly.
